// File: rtl/tmux_array_n.sv
// Temporal multiplexer array: compares each temporally encoded data channel against a
// shared temporally encoded select line, once per gamma cycle, all channels in parallel.
// MODE 0/1 match on first edge time (rising/falling); MODE 2 matches on pulse width and
// replays the matched width one gamma cycle later.
module tmux_array_n #(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8,
  parameter int unsigned NUM_INPUTS        = GAMMA_CYCLE_WIDTH,
  parameter int unsigned MODE              = 0,
  parameter int unsigned TOLERANCE         = 0
) (
  input  logic                                 clk,
  input  logic                                 grst,
  input  logic [NUM_INPUTS-1:0]                inputs,
  input  logic                                 select_line,
  output logic [NUM_INPUTS-1:0]                y,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] phase,
  output logic                                 cycle_start
);

  localparam int unsigned     PhW    = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int unsigned     CntW   = $clog2(PULSE_WIDTH + 1);
  localparam logic            Idle   = (MODE == 1);
  localparam logic [PhW-1:0]  LastPh = PhW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(PULSE_WIDTH);

  function automatic logic within_tol(input int unsigned a, input int unsigned b);
    int unsigned diff;
    diff = (a > b) ? (a - b) : (b - a);
    return diff <= TOLERANCE;
  endfunction

  logic [PhW-1:0]                  phase_q, phase_d;
  logic [NUM_INPUTS-1:0]           in_s_q;
  logic                            sel_s_q;
  logic [NUM_INPUTS-1:0]           prev_in_q, prev_in_d;
  logic                            prev_sel_q, prev_sel_d;
  logic [NUM_INPUTS-1:0]           cap_in_q, cap_in_d, cap_in_old;
  logic                            cap_sel_q, cap_sel_d, cap_sel_old;
  logic [NUM_INPUTS-1:0][PhW-1:0]  t_in_q, t_in_d;
  logic [PhW-1:0]                  t_sel_q, t_sel_d;
  logic [NUM_INPUTS-1:0][CntW-1:0] cnt_in_q, cnt_in_d, cnt_in_nx;
  logic [NUM_INPUTS-1:0][CntW-1:0] ocnt_q, ocnt_d;
  logic [CntW-1:0]                 cnt_sel_q, cnt_sel_d, cnt_sel_nx;
  logic [NUM_INPUTS-1:0]           y_q, y_d;
  logic                            ph_first, ph_last;
  logic [NUM_INPUTS-1:0]           act_in, evt_in;
  logic                            act_sel, evt_sel;

  // Phase counter and edge detection; everything below works in active-high terms.
  always_comb begin
    ph_first   = (phase_q == '0);
    ph_last    = (phase_q == LastPh);
    phase_d    = ph_last ? '0 : phase_q + 1'b1;
    act_in     = in_s_q ^ {NUM_INPUTS{Idle}};
    act_sel    = sel_s_q ^ Idle;
    prev_in_d  = act_in;
    prev_sel_d = act_sel;
    // Previous sample reads as idle at phase 0 so a level held across the boundary re-fires.
    evt_in     = act_in & ~(ph_first ? '0 : prev_in_q);
    evt_sel    = act_sel & ~(ph_first ? 1'b0 : prev_sel_q);
  end

  // Edge modes: latch the phase of the first event per cycle; captures drop at phase 0.
  always_comb begin
    cap_sel_old = cap_sel_q & ~ph_first;
    cap_sel_d   = cap_sel_old | evt_sel;
    t_sel_d     = (evt_sel & ~cap_sel_old) ? phase_q : t_sel_q;
    cap_in_old  = cap_in_q & {NUM_INPUTS{~ph_first}};
    cap_in_d    = cap_in_old | evt_in;
    t_in_d      = t_in_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (evt_in[i] && !cap_in_old[i]) t_in_d[i] = phase_q;
    end
  end

  // Pulse mode: saturating high-time counts, handed to the output stage at the cycle end.
  always_comb begin
    cnt_sel_nx = (act_sel && cnt_sel_q != CntMax) ? cnt_sel_q + 1'b1 : cnt_sel_q;
    cnt_sel_d  = ph_last ? '0 : cnt_sel_nx;
    cnt_in_nx  = cnt_in_q;
    cnt_in_d   = cnt_in_q;
    ocnt_d     = ocnt_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (act_in[i] && cnt_in_q[i] != CntMax) cnt_in_nx[i] = cnt_in_q[i] + 1'b1;
      if (ph_last) begin
        cnt_in_d[i] = '0;
        ocnt_d[i]   = (cnt_in_nx[i] != '0 && cnt_sel_nx != '0 &&
                       within_tol(32'(cnt_in_nx[i]), 32'(cnt_sel_nx))) ? cnt_in_nx[i] : '0;
      end else begin
        cnt_in_d[i] = cnt_in_nx[i];
      end
    end
  end

  // Output next state: edge modes set-and-hold within a cycle, pulse mode replays width.
  always_comb begin
    y_d = '0;
    if (MODE == 2) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (ph_last) y_d[i] = (ocnt_d[i] != '0);
        else         y_d[i] = (32'(phase_d) < 32'(ocnt_q[i]));
      end
    end else if (!ph_last) begin
      // A match found on the last phase would land on phase 0, which must stay idle.
      y_d = ph_first ? '0 : y_q;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (cap_in_d[i] && cap_sel_d && within_tol(32'(t_in_d[i]), 32'(t_sel_d))) begin
          y_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers; reset discards any partially captured cycle.
  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      phase_q    <= '0;
      in_s_q     <= {NUM_INPUTS{Idle}};
      sel_s_q    <= Idle;
      prev_in_q  <= '0;
      prev_sel_q <= 1'b0;
      cap_in_q   <= '0;
      cap_sel_q  <= 1'b0;
      t_in_q     <= '0;
      t_sel_q    <= '0;
      cnt_in_q   <= '0;
      cnt_sel_q  <= '0;
      ocnt_q     <= '0;
      y_q        <= '0;
    end else begin
      phase_q    <= phase_d;
      in_s_q     <= inputs;
      sel_s_q    <= select_line;
      prev_in_q  <= prev_in_d;
      prev_sel_q <= prev_sel_d;
      cap_in_q   <= cap_in_d;
      cap_sel_q  <= cap_sel_d;
      t_in_q     <= t_in_d;
      t_sel_q    <= t_sel_d;
      cnt_in_q   <= cnt_in_d;
      cnt_sel_q  <= cnt_sel_d;
      ocnt_q     <= ocnt_d;
      y_q        <= y_d;
    end
  end

  assign y           = y_q ^ {NUM_INPUTS{Idle}};
  assign phase       = phase_q;
  assign cycle_start = ph_first;

endmodule

// File: doc/tmux_array_n.md
TMUX_ARRAY_N -- requirements
Module: tmux_array_N

Interface
REQ-001 SHALL have parameter GAMMA_CYCLE_WIDTH, default 16: clocks per gamma cycle; legal range 4 or more.
REQ-002 SHALL have parameter PULSE_WIDTH, default 8: saturation limit of the pulse-width count; legal range 1 to GAMMA_CYCLE_WIDTH-2.
REQ-003 SHALL have parameter NUM_INPUTS, default GAMMA_CYCLE_WIDTH: number of data channels.
REQ-004 SHALL have parameter MODE, default 0: encoding; 0 rising-edge, 1 falling-edge, 2 pulse-width; other values illegal.
REQ-005 SHALL have parameter TOLERANCE, default 0: maximum absolute difference, in clocks, still counted as a match.
REQ-006 SHALL have port clk, input, width 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port grst, input, width 1: reset; asynchronous and active-high.
REQ-008 SHALL have port inputs, input, width NUM_INPUTS: temporally encoded data channels.
REQ-009 SHALL have port select_line, input, width 1: temporally encoded select, shared by all channels.
REQ-010 SHALL have port y, output, width NUM_INPUTS: per-channel match output, registered.
REQ-011 SHALL have port phase, output, width $clog2(GAMMA_CYCLE_WIDTH): current position within the gamma cycle.
REQ-012 SHALL have port cycle_start, output, width 1: equals 1 exactly when phase is 0.

Function
REQ-013 SHALL increment phase by 1 each clock and wrap from GAMMA_CYCLE_WIDTH-1 to 0.
REQ-014 SHALL register inputs and select_line once (the "sampled" signals) before any event detection.
REQ-015 SHALL define the idle level as 0 for MODE 0 and MODE 2, and 1 for MODE 1.
REQ-016 SHALL force each channel's previous-sample register to the idle level at phase 0, so a signal already active at cycle start counts as a transition at phase 0.
REQ-017 SHALL, in MODE 0 and MODE 1, latch the event time t as the phase of the first sampled transition from idle to active in the cycle; later transitions in the same cycle SHALL be ignored.
REQ-018 SHALL track t and a captured flag independently for each channel and for select_line, clearing all captured flags at phase 0.
REQ-019 SHALL, in MODE 0 and MODE 1, drive y[i] to the active level on the clock after both channel i and select are captured and |t_i - t_s| <= TOLERANCE; y[i] SHALL then hold until the end of the gamma cycle.
REQ-020 SHALL, in MODE 0 and MODE 1, return every y bit to the idle level at phase 0.
REQ-021 SHALL, in MODE 0 and MODE 1, produce no output when max(t_i, t_s) = GAMMA_CYCLE_WIDTH-1.
REQ-022 SHALL, in MODE 2, count the sampled-high clocks of each channel and of select within gamma cycle k, saturating at PULSE_WIDTH.
REQ-023 SHALL, in MODE 2, truncate the count at the cycle boundary: a pulse spanning the boundary SHALL NOT carry its count into the next cycle.
REQ-024 SHALL, in MODE 2, at phase 0 of cycle k+1 compare channel count c_i with select count c_s for match: both nonzero and |c_i - c_s| <= TOLERANCE.
REQ-025 SHALL, in MODE 2 on a match, drive y[i] high for phases 0 to c_i-1 of cycle k+1 and low otherwise; latency is exactly one gamma cycle.
REQ-026 SHALL, in MODE 2, clear all counts at phase 0 after transferring them into the output stage.
REQ-027 SHALL, when no select event occurs in a cycle, leave all y at the idle level, in every mode.
REQ-028 SHALL evaluate all channels in parallel, so any number of y bits may assert in the same clock.

Reset
REQ-029 SHALL, on grst = 1, immediately and asynchronously set: phase to 0, cycle_start to 1, y to the idle level (all ones in MODE 1, all zeros otherwise), and all captured flags, counts, event times and sampled registers to idle or zero.
REQ-030 SHALL, after grst deasserts, start the first gamma cycle at phase 0 on the next clock edge.
REQ-031 SHALL discard any partially captured event on a mid-cycle grst, producing no output for that cycle.

Verification
REQ-032 SHALL cover: MODE 0, G=16, inputs[3] and select both rise at phase 5 -> y[3] = 1 from phase 6 to 15, 0 at the next phase 0; other y bits stay 0.
REQ-033 SHALL cover: MODE 0, TOLERANCE=1, select rises at 4, inputs[0] at 5, inputs[1] at 7 -> y[0] = 1 from phase 6; y[1] stays 0.
REQ-034 SHALL cover: MODE 1, select and inputs[2] fall at phase 15 -> y stays all ones; at phase 3 of the next cycle -> y[2] = 0 from phase 4.
REQ-035 SHALL cover: MODE 2, PULSE_WIDTH=8, select high 3 clocks and inputs[1] high 3 clocks in cycle k -> y[1] high at phases 0 to 2 of cycle k+1; an input high 12 clocks against a select high 12 clocks -> y high for 8 clocks.
REQ-036 SHALL cover: grst asserted at phase 9 after select was captured at phase 2 -> y drops to idle at once; phase = 0; no match output from pre-reset events.
